// File: rtl/kwan_cpu_pkg.sv
// kwanCPU shared definitions: datapath sizing defaults
// and operand-fetch FSM encodings.
package kwan_cpu_pkg;

    localparam int XLEN_D = 8;
    localparam int N_D    = 8;
    localparam int A_D    = $clog2(N_D);

    typedef enum logic [1:0] {
        OF_EMPTY = 2'd0,
        OF_FRESH = 2'd1,
        OF_HELD  = 2'd2
    } of_state_e;

endpackage

// File: rtl/of_scoreboard.sv
// Pending-destination scoreboard for operand fetch:
// tracks outstanding writes and flags stray writebacks.
module of_scoreboard
    import kwan_cpu_pkg::*;
#(
    parameter int N = N_D,
    parameter int A = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_set_en,
    input  logic [A-1:0] i_set_addr,
    input  logic         i_clr_en,
    input  logic [A-1:0] i_clr_addr,
    input  logic [A-1:0] i_q0,
    input  logic [A-1:0] i_q1,
    input  logic [A-1:0] i_q2,
    output logic         o_hz0,
    output logic         o_hz1,
    output logic         o_hz2,
    output logic         o_err
);

    logic [N-1:0] r_pending;
    logic         r_err;
    logic [N-1:0] w_set_mask;
    logic [N-1:0] w_clr_mask;
    logic         w_clr_live;

    assign w_clr_live = i_clr_en && (i_clr_addr != '0);

    // A writeback landing this cycle resolves the hazard already
    function automatic logic hz(input logic [A-1:0] q);
        return (q != '0) && r_pending[q] &&
               !(i_clr_en && (i_clr_addr == q));
    endfunction

    assign o_hz0 = hz(i_q0);
    assign o_hz1 = hz(i_q1);
    assign o_hz2 = hz(i_q2);
    assign o_err = r_err;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en && (i_set_addr != '0))
            w_set_mask[i_set_addr] = 1'b1;
        if (w_clr_live)
            w_clr_mask[i_clr_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
            if (w_clr_live && !r_pending[i_clr_addr])
                r_err <= 1'b1;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// kwanCPU operand-fetch stage: regfile read, hazard stall,
// and a skid for operands when execute back-pressures.
module operand_fetch
    import kwan_cpu_pkg::*;
#(
    parameter int XLEN = XLEN_D,
    parameter int N    = N_D,
    parameter int A    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [A-1:0]    in_rs0,
    input  logic [A-1:0]    in_rs1,
    input  logic [A-1:0]    in_rd,
    input  logic            in_rd_we,
    output logic [A-1:0]    rf_addr0,
    output logic [A-1:0]    rf_addr1,
    input  logic [XLEN-1:0] rf_data0,
    input  logic [XLEN-1:0] rf_data1,
    input  logic            wb_we,
    input  logic [A-1:0]    wb_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op0,
    output logic [XLEN-1:0] out_op1,
    output logic [A-1:0]    out_rd,
    output logic            out_rd_we,
    output logic            sb_err
);

    of_state_e       r_state;
    logic [XLEN-1:0] r_held0;
    logic [XLEN-1:0] r_held1;
    logic [A-1:0]    r_rd;
    logic            r_rd_we;

    logic w_hz0;
    logic w_hz1;
    logic w_hz2;
    logic w_stall;
    logic w_accept;
    logic w_fresh;

    of_scoreboard #(
        .N (N),
        .A (A)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (w_accept && in_rd_we),
        .i_set_addr (in_rd),
        .i_clr_en   (wb_we),
        .i_clr_addr (wb_addr),
        .i_q0       (in_rs0),
        .i_q1       (in_rs1),
        .i_q2       (in_rd),
        .o_hz0      (w_hz0),
        .o_hz1      (w_hz1),
        .o_hz2      (w_hz2),
        .o_err      (sb_err)
    );

    assign w_stall  = w_hz0 || w_hz1 || (in_rd_we && w_hz2);
    assign in_ready = rst_n && !w_stall &&
                      ((r_state == OF_EMPTY) || out_ready);
    assign w_accept = in_valid && in_ready;

    // Write-first regfile covers same-cycle wb, so no bypass
    assign rf_addr0 = in_rs0;
    assign rf_addr1 = in_rs1;

    assign w_fresh   = (r_state == OF_FRESH);
    assign out_valid = (r_state != OF_EMPTY);
    assign out_op0   = w_fresh ? rf_data0 : r_held0;
    assign out_op1   = w_fresh ? rf_data1 : r_held1;
    assign out_rd    = r_rd;
    assign out_rd_we = r_rd_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OF_EMPTY;
            r_held0 <= '0;
            r_held1 <= '0;
            r_rd    <= '0;
            r_rd_we <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rd    <= in_rd;
                r_rd_we <= in_rd_we;
            end
            unique case (r_state)
                OF_EMPTY: begin
                    if (w_accept)
                        r_state <= OF_FRESH;
                end
                OF_FRESH: begin
                    if (out_ready) begin
                        r_state <= w_accept ? OF_FRESH : OF_EMPTY;
                    end else begin
                        r_state <= OF_HELD;
                        r_held0 <= rf_data0;
                        r_held1 <= rf_data1;
                    end
                end
                OF_HELD: begin
                    if (out_ready)
                        r_state <= w_accept ? OF_FRESH : OF_EMPTY;
                end
                default: r_state <= OF_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch paired with a
// write-first 2R1W regfile model.
module tb_operand_fetch;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_rs0;
    logic [2:0] in_rs1;
    logic [2:0] in_rd;
    logic       in_rd_we;
    logic [2:0] rf_addr0;
    logic [2:0] rf_addr1;
    logic [7:0] rf_data0;
    logic [7:0] rf_data1;
    logic       wb_we;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_op0;
    logic [7:0] out_op1;
    logic [2:0] out_rd;
    logic       out_rd_we;
    logic       sb_err;

    int checks;
    int failures;

    logic [7:0] rf [8];

    operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs0    (in_rs0),
        .in_rs1    (in_rs1),
        .in_rd     (in_rd),
        .in_rd_we  (in_rd_we),
        .rf_addr0  (rf_addr0),
        .rf_addr1  (rf_addr1),
        .rf_data0  (rf_data0),
        .rf_data1  (rf_data1),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op0   (out_op0),
        .out_op1   (out_op1),
        .out_rd    (out_rd),
        .out_rd_we (out_rd_we),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    // Regfile: sync read, write-first, r0 reads zero
    always @(posedge clk) begin
        if (wb_we && wb_addr != 3'd0)
            rf[wb_addr] <= wb_data;
        if (rf_addr0 == 3'd0)
            rf_data0 <= 8'h00;
        else if (wb_we && wb_addr == rf_addr0)
            rf_data0 <= wb_data;
        else
            rf_data0 <= rf[rf_addr0];
        if (rf_addr1 == 3'd0)
            rf_data1 <= 8'h00;
        else if (wb_we && wb_addr == rf_addr1)
            rf_data1 <= wb_data;
        else
            rf_data1 <= rf[rf_addr1];
    end

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks += 5;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_ready got=%0b exp=0", in_ready);
        end
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_out_valid got=%0b exp=0", out_valid);
        end
        if (out_op0 !== 8'h00 || out_op1 !== 8'h00) begin
            failures++;
            $display("FAIL rst_ops got=%h/%h exp=00/00", out_op0, out_op1);
        end
        if (sb_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_sb_err got=%0b exp=0", sb_err);
        end
        if (dut.u_sb.r_pending !== 8'h00) begin
            failures++;
            $display("FAIL rst_pending got=%h exp=00", dut.u_sb.r_pending);
        end
        // preload regfile while the stage is still held in reset
        wb_we = 1'b1; wb_addr = 3'd3; wb_data = 8'h5A;
        @(negedge clk);
        wb_addr = 3'd4; wb_data = 8'h11;
        @(negedge clk);
        wb_we = 1'b0;
        #1;
        checks++;
        if (sb_err !== 1'b0) begin
            failures++;
            $display("FAIL preload_sb_err got=%0b exp=0", sb_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        in_valid = 1'b1; in_rs0 = 3'd3; in_rs1 = 3'd4;
        in_rd = 3'd5; in_rd_we = 1'b1; out_ready = 1'b1;
        #1;
        checks += 2;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL t1_in_ready got=%0b exp=1", in_ready);
        end
        if (rf_addr0 !== 3'd3 || rf_addr1 !== 3'd4) begin
            failures++;
            $display("FAIL t1_rf_addr got=%0d/%0d exp=3/4", rf_addr0, rf_addr1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL t1_out_valid got=%0b exp=1", out_valid);
        end
        if (out_op0 !== 8'h5A || out_op1 !== 8'h11) begin
            failures++;
            $display("FAIL t1_ops got=%h/%h exp=5a/11", out_op0, out_op1);
        end
        if (out_rd !== 3'd5 || out_rd_we !== 1'b1) begin
            failures++;
            $display("FAIL t1_rd got=%0d/%0b exp=5/1", out_rd, out_rd_we);
        end
        if (dut.u_sb.r_pending !== 8'h20) begin
            failures++;
            $display("FAIL t1_pending got=%h exp=20", dut.u_sb.r_pending);
        end
    endtask

    task automatic test_raw_stall();
        @(negedge clk);
        in_valid = 1'b1; in_rs0 = 3'd5; in_rs1 = 3'd4;
        in_rd = 3'd6; in_rd_we = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL t2_stall got=%0b exp=0", in_ready);
        end
        @(negedge clk);
        wb_we = 1'b1; wb_addr = 3'd5; wb_data = 8'h77;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL t2_release got=%0b exp=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; wb_we = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b1 || out_rd_we !== 1'b0) begin
            failures++;
            $display("FAIL t2_out got=%0b/%0b exp=1/0", out_valid, out_rd_we);
        end
        if (out_op0 !== 8'h77 || out_op1 !== 8'h11) begin
            failures++;
            $display("FAIL t2_ops got=%h/%h exp=77/11", out_op0, out_op1);
        end
        if (dut.u_sb.r_pending !== 8'h00) begin
            failures++;
            $display("FAIL t2_pending got=%h exp=00", dut.u_sb.r_pending);
        end
        if (sb_err !== 1'b0) begin
            failures++;
            $display("FAIL t2_sb_err got=%0b exp=0", sb_err);
        end
    endtask

    task automatic test_r0();
        @(negedge clk);
        in_valid = 1'b1; in_rs0 = 3'd0; in_rs1 = 3'd0;
        in_rd = 3'd0; in_rd_we = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL t5_in_ready got=%0b exp=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wb_we = 1'b1; wb_addr = 3'd0; wb_data = 8'hFF;
        #1;
        checks += 2;
        if (out_valid !== 1'b1 || out_op0 !== 8'h00 || out_op1 !== 8'h00) begin
            failures++;
            $display("FAIL t5_ops got=%0b %h/%h exp=1 00/00", out_valid, out_op0, out_op1);
        end
        if (dut.u_sb.r_pending !== 8'h00) begin
            failures++;
            $display("FAIL t5_pending got=%h exp=00", dut.u_sb.r_pending);
        end
        @(negedge clk);
        wb_we = 1'b0;
        #1;
        checks++;
        if (sb_err !== 1'b0) begin
            failures++;
            $display("FAIL t5_sb_err got=%0b exp=0", sb_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] rs0_v [4];
        logic [2:0] rs1_v [4];
        logic [2:0] rd_v  [4];
        logic [7:0] e0_v  [4];
        logic [7:0] e1_v  [4];
        rs0_v = '{3'd3, 3'd4, 3'd5, 3'd0};
        rs1_v = '{3'd4, 3'd3, 3'd0, 3'd5};
        rd_v  = '{3'd6, 3'd7, 3'd1, 3'd2};
        e0_v  = '{8'h5A, 8'h11, 8'h77, 8'h00};
        e1_v  = '{8'h11, 8'h5A, 8'h00, 8'h77};
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin
                in_valid = 1'b1; in_rs0 = rs0_v[i]; in_rs1 = rs1_v[i];
                in_rd = rd_v[i]; in_rd_we = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL t4_in_ready[%0d] got=%0b exp=1", i, in_ready);
                end
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_op0 !== e0_v[i-1] ||
                    out_op1 !== e1_v[i-1] || out_rd !== rd_v[i-1]) begin
                    failures++;
                    $display("FAIL t4_out[%0d] got=%0b %h/%h rd%0d exp=1 %h/%h rd%0d",
                             i-1, out_valid, out_op0, out_op1, out_rd,
                             e0_v[i-1], e1_v[i-1], rd_v[i-1]);
                end
            end
        end
        @(negedge clk);
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL t4_drain got=%0b exp=0", out_valid);
        end
        if (dut.u_sb.r_pending !== 8'hC6) begin
            failures++;
            $display("FAIL t4_pending got=%h exp=c6", dut.u_sb.r_pending);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b1; in_rs0 = 3'd3; in_rs1 = 3'd4;
        in_rd = 3'd5; in_rd_we = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL t3_in_ready got=%0b exp=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_op0 !== 8'h5A) begin
            failures++;
            $display("FAIL t3_fresh got=%0b %h exp=1 5a", out_valid, out_op0);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (j == 1) begin
                wb_we = 1'b1; wb_addr = 3'd3; wb_data = 8'h99;
            end else begin
                wb_we = 1'b0;
            end
            #1;
            checks += 2;
            if (out_valid !== 1'b1 || out_op0 !== 8'h5A ||
                out_op1 !== 8'h11 || out_rd !== 3'd5) begin
                failures++;
                $display("FAIL t3_hold[%0d] got=%0b %h/%h rd%0d exp=1 5a/11 rd5",
                         j, out_valid, out_op0, out_op1, out_rd);
            end
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL t3_hold_ready[%0d] got=%0b exp=0", j, in_ready);
            end
        end
        checks++;
        if (sb_err !== 1'b1) begin
            failures++;
            $display("FAIL t3_sb_err got=%0b exp=1", sb_err);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_op0 !== 8'h5A) begin
            failures++;
            $display("FAIL t3_xfer got=%0b %h exp=1 5a", out_valid, out_op0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || sb_err !== 1'b1) begin
            failures++;
            $display("FAIL t3_empty got=%0b err%0b exp=0 err1", out_valid, sb_err);
        end
    endtask

    task automatic test_reset_mid_held();
        @(negedge clk);
        in_valid = 1'b1; in_rs0 = 3'd3; in_rs1 = 3'd4;
        in_rd = 3'd0; in_rd_we = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL t6_in_ready got=%0b exp=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || dut.u_sb.r_pending !== 8'hE6) begin
            failures++;
            $display("FAIL t6_pre got=%0b %h exp=1 e6", out_valid, dut.u_sb.r_pending);
        end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL t6_valid got=%0b/%0b exp=0/0", out_valid, in_ready);
        end
        if (dut.u_sb.r_pending !== 8'h00) begin
            failures++;
            $display("FAIL t6_pending got=%h exp=00", dut.u_sb.r_pending);
        end
        if (sb_err !== 1'b0) begin
            failures++;
            $display("FAIL t6_sb_err got=%0b exp=0", sb_err);
        end
        if (out_op0 !== 8'h00 || out_rd !== 3'd0) begin
            failures++;
            $display("FAIL t6_out got=%h rd%0d exp=00 rd0", out_op0, out_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_rs0    = 3'd0;
        in_rs1    = 3'd0;
        in_rd     = 3'd0;
        in_rd_we  = 1'b0;
        wb_we     = 1'b0;
        wb_addr   = 3'd0;
        wb_data   = 8'h00;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_raw_stall();
        test_r0();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
